// File: rtl/capture_readout_pkg.sv
// Shared definitions for the sample-memory readout path and the capture-side
// delay line, so both agree on sample width and capture latency.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package capture_readout_pkg;

    localparam int CR_DATA_WIDTH = `DATA_WIDTH;

    // Writes between trigger detection and the trigger sample landing in RAM.
    localparam int CR_PIPE_DELAY = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } cr_state_e;

endpackage

// File: rtl/capture_readout_skid_buf.sv
// Two-entry valid/ready buffer between the RAM read port and the output stream.
// An arriving sample bypasses straight to the output when the buffer is empty,
// so back-to-back streaming holds zero entries and runs at one sample per cycle.
module readout_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] e0_q;
    logic [DATA_WIDTH-1:0] e1_q;
    logic [1:0]            cnt_q;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign empty       = (cnt_q == 2'd0);
    assign out_valid_o = !empty || in_valid_i;
    assign out_data_o  = !empty ? e0_q : (in_valid_i ? in_data_i : '0);
    assign count_o     = cnt_q;

    // Store the incoming sample unless it passes straight through this cycle.
    assign pop  = !empty && out_ready_i;
    assign push = in_valid_i && !(empty && out_ready_i);

    // Entry storage and occupancy; flush discards everything held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (empty) e0_q <= in_data_i;
                    else       e1_q <= in_data_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_q <= in_data_i;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/capture_readout.sv
// Reads one full window back from the circular sample RAM after a trigger and
// streams it over valid/ready, starting pre_count samples before the trigger.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing RAM reads (credit-limited) and streaming samples
// DRAIN  | all reads issued, emptying the buffer until the last beat leaves
module capture_readout
    import capture_readout_pkg::*;
#(
    parameter int DATA_WIDTH = CR_DATA_WIDTH,
    parameter int ADDR_WIDTH = 10,
    parameter int PIPE_DELAY = CR_PIPE_DELAY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] trig_addr,
    input  logic [ADDR_WIDTH-1:0] pre_count,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last,
    output logic                  busy,
    output logic                  done
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

    cr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic [ADDR_WIDTH:0]   beats_q, beats_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;
    logic                  flush;
    logic [1:0]            buf_cnt;
    logic [1:0]            credit;
    logic                  beat;

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    assign flush   = abort && (state_q != IDLE);
    assign credit  = buf_cnt + {1'b0, inflight_q};
    assign beat    = o_valid && o_ready;
    assign o_last  = o_valid && (beats_q == LAST_IDX);

    readout_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (flush),
        .in_valid_i  (inflight_q),
        .in_data_i   (rd_data),
        .out_valid_o (o_valid),
        .out_data_o  (o_data),
        .out_ready_i (o_ready),
        .count_o     (buf_cnt)
    );

    // Next-state, read issue and window bookkeeping.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        issued_d   = issued_q;
        beats_d    = beats_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;

        if (beat) beats_d = beats_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STREAM;
                    // pre_count is ADDR_WIDTH bits wide, so it never exceeds
                    // DEPTH-1 and needs no further clamping.
                    base_d   = trig_addr + ADDR_WIDTH'(PIPE_DELAY) - pre_count;
                    issued_d = '0;
                    beats_d  = '0;
                end
            end
            STREAM: begin
                // At most two samples outstanding between RAM and output.
                rd_en = (credit < 2'd2);
                if (rd_en) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat && o_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d = rd_en;

        if (flush) begin
            state_d    = IDLE;
            inflight_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            issued_q   <= '0;
            beats_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            beats_q    <= beats_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout: 16-entry RAM holding mem[i] = i.
module tb_capture_readout;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          o_ready   = 1'b1;
    logic [AW-1:0] trig_addr = '0;
    logic [AW-1:0] pre_count = '0;
    logic [DW-1:0] rd_data   = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int            done_cnt;
    int            first_valid_cyc;
    int            stall_errs;
    int            max_out;
    int            cycles;
    bit            timed_out;

    always #5 clk = ~clk;

    // Synchronous RAM: data one cycle after the read strobe.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    capture_readout #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PIPE_DELAY (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .trig_addr (trig_addr),
        .pre_count (pre_count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_last    (o_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic do_start(input logic [AW-1:0] t, input logic [AW-1:0] p);
        @(negedge clk);
        trig_addr = t;
        pre_count = p;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        trig_addr = AW'($urandom);
        pre_count = AW'($urandom);
    endtask

    // Records accepted beats until busy falls, max_beats is reached or the
    // cycle budget expires. mode: 0 ready high, 1 ready toggling, 2 random.
    task automatic collect(input int mode, input int max_beats, input bit inject_start);
        int            cyc      = 0;
        int            issued   = 0;
        int            accepted = 0;
        bit            pv       = 1'b0;
        bit            injected = 1'b0;
        logic [DW-1:0] pd       = '0;
        logic          pl       = 1'b0;
        got_data.delete();
        got_last.delete();
        done_cnt        = 0;
        first_valid_cyc = -1;
        stall_errs      = 0;
        max_out         = 0;
        timed_out       = 1'b0;
        forever begin
            #1;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (pv && !(o_valid === 1'b1 && o_data === pd && o_last === pl)) stall_errs++;
            if (done === 1'b1) done_cnt++;
            if (o_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rd_en === 1'b1) issued++;
            pv = (o_valid === 1'b1) && !o_ready;
            pd = o_data;
            pl = o_last;
            if (o_valid === 1'b1 && o_ready) begin
                accepted++;
                got_data.push_back(o_data);
                got_last.push_back(o_last);
            end
            cycles = cyc;
            if (busy !== 1'b1) break;
            if (max_beats > 0 && accepted >= max_beats) break;
            if (cyc >= 300) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            case (mode)
                0:       o_ready = 1'b1;
                1:       o_ready = (cyc % 2 == 0);
                default: o_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (inject_start && !injected && accepted == 5) begin
                start     = 1'b1;
                trig_addr = 4'd0;
                pre_count = 4'd0;
                injected  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({o_valid, rd_en, busy, done, o_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {o_valid,rd_en,busy,done,o_last}=%b required 00000",
                     {o_valid, rd_en, busy, done, o_last});
        end
        checks++;
        if (o_data !== '0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_data: o_data=%h rd_addr=%h required 0 and 0", o_data, rd_addr);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int bad = 0;
        o_ready = 1'b1;
        do_start(4'd5, 4'd2);
        #1;
        checks++;
        if ({rd_en, busy, o_valid} !== 3'b110 || rd_addr !== 4'd6) begin
            errors++;
            $display("FAIL basic_issue: rd_en,busy,o_valid=%b rd_addr=%0d required 110 and 6",
                     {rd_en, busy, o_valid}, rd_addr);
        end
        collect(0, 0, 1'b0);
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'((6 + i) % 16) || got_last[i] !== (i == 15)) bad++;
        checks++;
        if (got_data.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL basic_seq: %0d beats with %0d wrong, required 16 beats with 0 wrong",
                     got_data.size(), bad);
        end
        checks++;
        if (done_cnt != 1 || timed_out) begin
            errors++;
            $display("FAIL basic_done: done pulses=%0d timeout=%0d required 1 and 0", done_cnt, timed_out);
        end
        checks++;
        if (first_valid_cyc != 1 || cycles != 17) begin
            errors++;
            $display("FAIL basic_timing: first valid at %0d, idle at %0d, required 1 and 17",
                     first_valid_cyc, cycles);
        end
    endtask

    task automatic test_wrap;
        int bad = 0;
        do_start(4'd14, 4'd0);
        collect(0, 0, 1'b0);
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'((1 + i) % 16) || got_last[i] !== (i == 15)) bad++;
        checks++;
        if (got_data.size() != 16 || bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL wrap_seq: %0d beats, %0d wrong, %0d done, required 16, 0, 1",
                     got_data.size(), bad, done_cnt);
        end
    endtask

    task automatic test_clamp;
        int bad = 0;
        logic [AW-1:0] p20 = AW'(20);
        do_start(4'd5, p20);
        collect(0, 0, 1'b0);
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'((4 + i) % 16) || got_last[i] !== (i == 15)) bad++;
        checks++;
        if (got_data.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL clamp_pre20: %0d beats with %0d wrong, required 16 with 0 wrong",
                     got_data.size(), bad);
        end
        bad = 0;
        do_start(4'd5, 4'd15);
        collect(0, 0, 1'b0);
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'((9 + i) % 16) || got_last[i] !== (i == 15)) bad++;
        checks++;
        if (got_data.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL clamp_pre15: %0d beats with %0d wrong, required 16 with 0 wrong",
                     got_data.size(), bad);
        end
    endtask

    task automatic test_backpressure;
        for (int m = 1; m <= 2; m++) begin
            int bad = 0;
            do_start(4'd5, 4'd2);
            collect(m, 0, 1'b0);
            for (int i = 0; i < got_data.size(); i++)
                if (got_data[i] !== 8'((6 + i) % 16) || got_last[i] !== (i == 15)) bad++;
            checks++;
            if (got_data.size() != 16 || bad != 0 || done_cnt != 1) begin
                errors++;
                $display("FAIL bp_seq mode %0d: %0d beats, %0d wrong, %0d done, required 16, 0, 1",
                         m, got_data.size(), bad, done_cnt);
            end
            checks++;
            if (stall_errs != 0 || max_out > 2) begin
                errors++;
                $display("FAIL bp_hold mode %0d: %0d unstable stalls, %0d outstanding, required 0 and <=2",
                         m, stall_errs, max_out);
            end
        end
        o_ready = 1'b1;
    endtask

    task automatic test_start_while_busy;
        int bad = 0;
        do_start(4'd10, 4'd3);
        collect(0, 0, 1'b1);
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'((10 + i) % 16) || got_last[i] !== (i == 15)) bad++;
        checks++;
        if (got_data.size() != 16 || bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start: %0d beats, %0d wrong, %0d done, required 16, 0, 1",
                     got_data.size(), bad, done_cnt);
        end
    endtask

    task automatic test_abort;
        int bad = 0;
        int dc  = 0;
        int vc  = 0;
        do_start(4'd0, 4'd0);
        collect(0, 7, 1'b0);
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'(3 + i) || got_last[i] !== 1'b0) bad++;
        checks++;
        if (got_data.size() != 7 || bad != 0) begin
            errors++;
            $display("FAIL abort_prefix: %0d beats with %0d wrong, required 7 with 0 wrong",
                     got_data.size(), bad);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: o_valid=%b busy=%b rd_en=%b required 0 0 0", o_valid, busy, rd_en);
        end
        if (done === 1'b1) dc++;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) dc++;
            if (o_valid === 1'b1) vc++;
        end
        checks++;
        if (dc != 0 || vc != 0) begin
            errors++;
            $display("FAIL abort_quiet: done pulses=%0d valid cycles=%0d required 0 and 0", dc, vc);
        end
        // start and abort together in IDLE: start is taken
        @(negedge clk);
        trig_addr = 4'd7;
        pre_count = 4'd7;
        start     = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        collect(0, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'((3 + i) % 16) || got_last[i] !== (i == 15)) bad++;
        checks++;
        if (got_data.size() != 16 || bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart: %0d beats, %0d wrong, %0d done, required 16, 0, 1",
                     got_data.size(), bad, done_cnt);
        end
    endtask

    task automatic test_async_reset;
        int   bad = 0;
        logic busy_before;
        do_start(4'd5, 4'd2);
        repeat (3) @(negedge clk);
        #1;
        busy_before = busy;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (busy_before !== 1'b1 || {o_valid, rd_en, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset: busy before=%b {o_valid,rd_en,busy,done}=%b required 1 and 0000",
                     busy_before, {o_valid, rd_en, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        do_start(4'd3, 4'd1);
        collect(0, 0, 1'b0);
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'((5 + i) % 16) || got_last[i] !== (i == 15)) bad++;
        checks++;
        if (got_data.size() != 16 || bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL reset_restart: %0d beats, %0d wrong, %0d done, required 16, 0, 1",
                     got_data.size(), bad, done_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_backpressure();
        test_start_while_busy();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Reader side of the analyzer's sample memory.
- The capture path runs the probe data through a fixed 3-cycle delay line and writes it into a circular RAM. This block reads that RAM back after a trigger and streams one full window out over a valid/ready interface toward the host/UART link.
- The window starts `pre_count` samples before the trigger sample, compensating for the capture-path delay.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (8): sample width.
- ADDR_WIDTH, default 10: RAM address width; DEPTH = 2**ADDR_WIDTH samples per window.
- PIPE_DELAY, default 3: capture-path latency, in writes, between trigger detection and the trigger sample landing in RAM.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request to begin readout; honoured only in IDLE.
- abort, in, 1: synchronous cancel of readout.
- trig_addr, in, ADDR_WIDTH: write pointer at trigger detection; sampled on an accepted start.
- pre_count, in, ADDR_WIDTH: number of pre-trigger samples; sampled on an accepted start.
- rd_en, out, 1: RAM read strobe.
- rd_addr, out, ADDR_WIDTH: RAM read address.
- rd_data, in, DATA_WIDTH: RAM output, valid exactly 1 cycle after rd_en.
- o_data, out, DATA_WIDTH: streamed sample.
- o_valid, out, 1: o_data is valid.
- o_ready, in, 1: downstream accepts the sample.
- o_last, out, 1: marks the final sample of the window.
- busy, out, 1: high from start acceptance until done or abort.
- done, out, 1: one-cycle pulse at window completion.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; FSM to IDLE; skid buffer empty; counters 0.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE -> STREAM on start=1.
  - STREAM -> DRAIN once DEPTH reads have been issued.
  - DRAIN -> IDLE when the o_last beat is accepted; done=1 in that cycle's following edge (one-cycle pulse).
- On an accepted start:
  - pc = min(pre_count, DEPTH-1).
  - base = (trig_addr + PIPE_DELAY - pc) mod DEPTH.
  - Read counter is cleared; busy=1 from the next cycle.
- Read issue:
  - rd_en=1 only when (buffered entries + in-flight reads) < 2.
  - rd_addr = (base + issued) mod DEPTH; natural wrap from DEPTH-1 to 0.
  - Exactly DEPTH reads per window.
- Output buffer:
  - A 2-entry skid buffer captures rd_data one cycle after each rd_en.
  - With o_ready held high, streaming runs at 1 sample/cycle.
  - First o_valid appears 2 cycles after start (1 cycle to issue, 1 cycle of RAM latency).
- Handshake rules:
  - A beat transfers when o_valid & o_ready.
  - While o_valid=1 and o_ready=0, o_data and o_last hold stable and o_valid stays high.
  - No sample is dropped or duplicated.
- o_last=1 only on the DEPTH-th beat.
- Ignored inputs:
  - start while busy=1 is ignored.
  - trig_addr and pre_count changes after acceptance have no effect.
- abort=1 in STREAM or DRAIN:
  - Next cycle: o_valid=0, buffer flushed, in-flight read discarded, FSM to IDLE, busy=0.
  - No done pulse.
  - abort in IDLE has no effect.
  - abort and start in the same cycle in IDLE: start wins.
- Reset mid-window: immediate return to the reset state; a fresh start is required afterwards.
- Arithmetic: all address math is ADDR_WIDTH-bit modulo. The beat counter is ADDR_WIDTH+1 bits so that DEPTH is representable.

Decomposition:
- Shared package/define file holds:
  - DATA_WIDTH (existing `DATA_WIDTH).
  - FSM state encodings: IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2.
  - PIPE_DELAY default, shared with the capture-side delay line so both stay consistent.
- One sub-module: readout_skid_buf, a 2-entry valid/ready buffer with a count output (used for the read-issue credit) and a flush input (used by abort).

Test Plan:
Common setup: ADDR_WIDTH=4, DEPTH=16, PIPE_DELAY=3, RAM preloaded with mem[i]=i.
- Basic window: o_ready=1, start with trig_addr=5, pre_count=2 -> first rd_addr=6; o_data sequence 6..15 then 0..5; o_last on the beat carrying 5; 16 beats total; done pulses once; busy then falls.
- Wrap: trig_addr=14, pre_count=0 -> base=1; o_data 1..15 then 0; o_last on 0.
- Clamp: trig_addr=5, pre_count=20 (truncated to 4 bits = 4) -> base=4. Separately, with pre_count=15 -> base=9; sequence 9..15 then 0..8.
- Backpressure: o_ready toggling 1,0,1,0 and random stalls -> o_data stable during every stall; still exactly 16 in-order beats; at most 2 reads outstanding+buffered at any time.
- Start while busy, then abort:
  - Second start mid-window -> ignored, sequence unaffected.
  - abort after beat 7 -> o_valid=0 next cycle, busy=0, no done.
  - A new start afterwards -> full, correct window.
- Async reset: drop reset mid-STREAM between clock edges -> o_valid, rd_en, busy, done all 0 immediately; after release, start yields a correct window.
